seq_eq: RTL and testbench

Sequential, parametrised successor to the single-bit combinational equality gate: compares two unsigned WIDTH-bit operands chunk by chunk, MSB chunk first, STEP bits per clock. It reports eq/gt/lt plus the compare-cycle count, under a start/busy/done handshake. It sits between operand registers and control logic in the lab datapath, where a full-width parallel comparator is too wide or too slow.

---
 rtl/seq_eq_pkg.sv | 24 ++
 rtl/seq_eq_eq_chunk.sv | 28 ++
 rtl/seq_eq.sv | 199 +++++++++++++++++++
 tb/tb_seq_eq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_eq_pkg.sv
// ----------------------------------------------------------------------------
// seq_eq_pkg
//
// Shared declarations for the sequential chunked comparator (seq_eq).
//
// Contents:
//   state_e    - controller states: idle, comparing, result-valid
//   cnt_width  - width of the compare-cycle counter for a given chunk count,
//                sized so that the value NSTEP itself is representable
// ----------------------------------------------------------------------------
package seq_eq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmp  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Counter must hold 0..nstep inclusive.
    function automatic int unsigned cnt_width(input int unsigned nstep);
        return $clog2(nstep + 1);
    endfunction

endpackage

// File: rtl/seq_eq_eq_chunk.sv
// ----------------------------------------------------------------------------
// eq_chunk
//
// Combinational STEP-bit unsigned comparator used by seq_eq on the current
// most-significant chunk of its operand shift registers.
//
// Parameters:
//   STEP  - chunk width in bits (>= 1)
//
// Ports:
//   a  in   STEP  chunk of operand A
//   b  in   STEP  chunk of operand B
//   e  out  1     a == b
//   g  out  1     a >  b (unsigned)
// ----------------------------------------------------------------------------
module eq_chunk #(
    parameter int unsigned STEP = 1
) (
    input  logic [STEP-1:0] a,
    input  logic [STEP-1:0] b,
    output logic            e,
    output logic            g
);

    assign e = (a == b);
    assign g = (a > b);

endmodule

// File: rtl/seq_eq.sv
// ----------------------------------------------------------------------------
// seq_eq
//
// Sequential unsigned magnitude comparator. Two WIDTH-bit operands are
// captured on an accepted start and compared STEP bits per clock, most
// significant chunk first. The first unequal chunk decides gt/lt; later
// chunks cannot change the decision. Results (eq/gt/lt/cycles) are registered
// when the controller enters its result state and are held until the next
// operation's result replaces them.
//
// Build option:
//   EARLY_EXIT_EN  when defined, comparison stops at the first mismatching
//                  chunk and cycles reports that chunk's 1-based index.
//                  When undefined, all NSTEP chunks are always evaluated and
//                  cycles == NSTEP (data-independent latency). eq/gt/lt are
//                  the same in both builds.
//
// Parameters:
//   WIDTH  - operand width in bits (>= 1)
//   STEP   - bits compared per cycle; WIDTH must be a multiple of STEP
//
// Ports:
//   clk     in   1       clock, rising edge
//   rst     in   1       synchronous active-high reset, priority over start
//   start   in   1       request, accepted only while busy == 0
//   x       in   WIDTH   operand A, sampled on accepted start
//   y       in   WIDTH   operand B, sampled on accepted start
//   busy    out  1       operation in progress (compare or result state)
//   done    out  1       one-cycle pulse, results valid
//   eq      out  1       x == y
//   gt      out  1       x >  y (unsigned)
//   lt      out  1       x <  y (unsigned)
//   cycles  out  CW      compare cycles used for the last result
// ----------------------------------------------------------------------------
module seq_eq
    import seq_eq_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned STEP  = 1,
    localparam int unsigned NSTEP = WIDTH / STEP,
    localparam int unsigned CW    = cnt_width(NSTEP)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [CW-1:0]    cycles
);

`ifdef EARLY_EXIT_EN
    localparam bit EarlyExit = 1'b1;
`else
    localparam bit EarlyExit = 1'b0;
`endif

    // Counter value while the final chunk is on the comparator.
    localparam logic [CW-1:0] LastCnt = CW'(NSTEP - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mis_q, mis_d;          // a mismatching chunk has been seen
    logic             gt_seen_q, gt_seen_d;  // direction of that first mismatch
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic [CW-1:0]    cycles_q, cycles_d;

    // ------------------------------------------------------------------------
    // Chunk comparator on the top STEP bits of the shift registers
    // ------------------------------------------------------------------------
    logic [STEP-1:0] x_chunk;
    logic [STEP-1:0] y_chunk;
    logic            chunk_eq;
    logic            chunk_gt;

    assign x_chunk = xs_q[WIDTH-1 -: STEP];
    assign y_chunk = ys_q[WIDTH-1 -: STEP];

    eq_chunk #(
        .STEP (STEP)
    ) u_chunk (
        .a (x_chunk),
        .b (y_chunk),
        .e (chunk_eq),
        .g (chunk_gt)
    );

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic last_chunk;
    logic mis_now;   // mismatch flag including the chunk evaluated this cycle
    logic gt_now;    // decision including the chunk evaluated this cycle

    always_comb begin
        state_d   = state_q;
        xs_d      = xs_q;
        ys_d      = ys_q;
        cnt_d     = cnt_q;
        mis_d     = mis_q;
        gt_seen_d = gt_seen_q;
        eq_d      = eq_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        cycles_d  = cycles_q;

        last_chunk = (cnt_q == LastCnt);
        mis_now    = mis_q | ~chunk_eq;
        // Once a mismatch is recorded its direction is frozen.
        gt_now     = mis_q ? gt_seen_q : chunk_gt;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StCmp;
                    xs_d      = x;
                    ys_d      = y;
                    cnt_d     = '0;
                    mis_d     = 1'b0;
                    gt_seen_d = 1'b0;
                end
            end

            StCmp: begin
                xs_d      = xs_q << STEP;
                ys_d      = ys_q << STEP;
                cnt_d     = cnt_q + 1'b1;
                mis_d     = mis_now;
                gt_seen_d = gt_now;
                if (last_chunk || (EarlyExit && !chunk_eq)) begin
                    state_d  = StDone;
                    eq_d     = ~mis_now;
                    gt_d     = mis_now & gt_now;
                    lt_d     = mis_now & ~gt_now;
                    cycles_d = cnt_q + 1'b1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            xs_q      <= '0;
            ys_q      <= '0;
            cnt_q     <= '0;
            mis_q     <= 1'b0;
            gt_seen_q <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            xs_q      <= xs_d;
            ys_q      <= ys_d;
            cnt_q     <= cnt_d;
            mis_q     <= mis_d;
            gt_seen_q <= gt_seen_d;
            eq_q      <= eq_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            cycles_q  <= cycles_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs, all decoded from or taken directly from flops
    // ------------------------------------------------------------------------
    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign eq     = eq_q;
    assign gt     = gt_q;
    assign lt     = lt_q;
    assign cycles = cycles_q;

endmodule

// File: tb/tb_seq_eq.sv
// ----------------------------------------------------------------------------
// tb_seq_eq
//
// Bench for seq_eq with two instances: u_a (WIDTH=8, STEP=1) and
// u_b (WIDTH=8, STEP=4). Expected results come from a behavioural model and
// are queued when an operation is started, then popped when done appears.
// Honours EARLY_EXIT_EN for expected latency and cycle counts.
// ----------------------------------------------------------------------------
module tb_seq_eq;

`ifdef EARLY_EXIT_EN
    localparam bit EarlyExit = 1'b1;
`else
    localparam bit EarlyExit = 1'b0;
`endif

    typedef struct packed {
        logic       eq;
        logic       gt;
        logic       lt;
        logic [3:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       sel;
    logic [7:0] x;
    logic [7:0] y;
    logic       start_a;
    logic       start_b;

    logic       busy_a, done_a, eq_a, gt_a, lt_a;
    logic [3:0] cyc_a;
    logic       busy_b, done_b, eq_b, gt_b, lt_b;
    logic [1:0] cyc_b;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    seq_eq #(
        .WIDTH (8),
        .STEP  (1)
    ) u_a (
        .clk    (clk),
        .rst    (rst),
        .start  (start_a),
        .x      (x),
        .y      (y),
        .busy   (busy_a),
        .done   (done_a),
        .eq     (eq_a),
        .gt     (gt_a),
        .lt     (lt_a),
        .cycles (cyc_a)
    );

    seq_eq #(
        .WIDTH (8),
        .STEP  (4)
    ) u_b (
        .clk    (clk),
        .rst    (rst),
        .start  (start_b),
        .x      (x),
        .y      (y),
        .busy   (busy_b),
        .done   (done_b),
        .eq     (eq_b),
        .gt     (gt_b),
        .lt     (lt_b),
        .cycles (cyc_b)
    );

    // Observed outputs of the currently selected instance.
    logic       o_busy, o_done, o_eq, o_gt, o_lt;
    logic [3:0] o_cyc;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_eq   = sel ? eq_b : eq_a;
    assign o_gt   = sel ? gt_b : gt_a;
    assign o_lt   = sel ? lt_b : lt_a;
    assign o_cyc  = sel ? {2'b00, cyc_b} : cyc_a;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t prev [2];
    bit   seen_rst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int step);
        exp_t       r;
        int         nstep;
        int         first;
        logic [7:0] ta;
        logic [7:0] tb;
        nstep = 8 / step;
        first = 0;
        for (int i = 0; i < nstep; i++) begin
            ta = (a << (i * step)) >> (8 - step);
            tb = (b << (i * step)) >> (8 - step);
            if (first == 0 && ta != tb) first = i + 1;
        end
        r.eq  = (a == b);
        r.gt  = (a > b);
        r.lt  = (a < b);
        r.cyc = 4'((EarlyExit && first != 0) ? first : nstep);
        return r;
    endfunction

    // One operation on instance s; abuse re-pulses start and wiggles x/y
    // while the compare is running and again during the result cycle.
    task automatic run(input logic s, input logic [7:0] xv, input logic [7:0] yv,
                       input bit abuse);
        exp_t e;
        int   lat;
        bit   seen;
        sel   = s;
        x     = xv;
        y     = yv;
        start = 1'b1;
        sb.push_back(model(xv, yv, s ? 4 : 1));
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 32'(o_busy), 32'd1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (abuse) begin
                start = (lat >= 1 && lat <= 3);
                x     = ~xv;
                y     = xv ^ 8'h5a;
            end
            if (o_done) begin
                seen = 1'b1;
            end else if (lat == 1) begin
                chk("result_held", 32'({o_eq, o_gt, o_lt, o_cyc}), 32'(prev[s]));
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        e = sb.pop_front();
        chk("eq", 32'(o_eq), 32'(e.eq));
        chk("gt", 32'(o_gt), 32'(e.gt));
        chk("lt", 32'(o_lt), 32'(e.lt));
        chk("cycles", 32'(o_cyc), 32'(e.cyc));
        chk("latency", 32'(lat), 32'(e.cyc));
        prev[s] = e;
        if (abuse) start = 1'b1;  // lands on the result cycle, must be ignored
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_pulse_len", 32'(o_done), 32'd0);
        chk("busy_fall", 32'(o_busy), 32'd0);
        chk("result_kept", 32'({o_eq, o_gt, o_lt, o_cyc}), 32'(e));
    endtask

    initial begin
        prev[0] = '0;
        prev[1] = '0;
        sel     = 1'b0;
        x       = 8'h00;
        y       = 8'h00;
        rst     = 1'b1;
        start   = 1'b1;  // must be ignored while in reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_res_a", 32'({eq_a, gt_a, lt_a, cyc_a}), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        chk("rst_res_b", 32'({done_b, eq_b, gt_b, lt_b, cyc_b}), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after_rst", 32'(busy_a), 32'd0);

        run(1'b0, 8'ha5, 8'ha5, 1'b0);
        run(1'b0, 8'h80, 8'h7f, 1'b0);
        run(1'b1, 8'h12, 8'h13, 1'b0);
        run(1'b1, 8'h3c, 8'h3c, 1'b0);
        run(1'b1, 8'h52, 8'h13, 1'b0);
        run(1'b0, 8'h3c, 8'h3d, 1'b1);
        run(1'b0, 8'h0f, 8'h0f, 1'b0);

        // Reset in the middle of an operation.
        sel   = 1'b0;
        x     = 8'hff;
        y     = 8'h00;
        start = 1'b1;
        sb.push_back(model(8'hff, 8'h00, 1));
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_done", 32'(done_a), 32'd0);
        chk("midrst_res", 32'({eq_a, gt_a, lt_a, cyc_a}), 32'd0);
        sb.delete();
        prev[0]  = '0;
        prev[1]  = '0;
        seen_rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done_a) seen_rst = 1'b1;
        end
        chk("no_done_after_rst", 32'(seen_rst), 32'd0);

        run(1'b0, 8'h01, 8'h02, 1'b0);
        run(1'b1, 8'hf0, 8'h0f, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
